fec_codec_seq: RTL

Multi-bank, row-serial successor to the streaming FEC codec for the CSNC datapath. It accepts one M-symbol beat per handshake and lifts each DATA_W-bit symbol to WIDTH bits. It applies an M×M decode matrix, then an M×M encode matrix, both in GF(2)[x]/(x^WIDTH−1), and projects the result back to DATA_W bits. The coefficients come from one of NBANK independently writable banks, selected per beat, so software can reload one bank while another carries traffic. The block computes one matrix row per cycle to save multipliers, and sits between the packet deframer and the symbol scheduler.

---
 rtl/fec_codec_seq.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fec_codec_seq.sv
// Row-serial two-stage GF(2)[x]/(x^WIDTH-1) matrix codec (decode then encode) with NBANK coefficient banks.
// Latency: 2*M+1 cycles from beat acceptance to out_valid; one beat in flight at a time.
// Backpressure: in_ready low while busy; result held in HOLD until out_ready; cfg writes to the busy bank stall.
// Optional macro FEC_CODEC_SEQ_DEBUG_EN exposes the decoded vector on debug_decoded_flat.
module fec_codec_seq #(
    parameter int M       = 3,
    parameter int WIDTH   = 11,
    parameter int DATA_W  = WIDTH - 1,
    parameter int NBANK   = 2,
    parameter int INDEX_W = (M * M > 1) ? $clog2(M * M) : 1,
    parameter int BANK_W  = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    output logic                  cfg_ready,
    input  logic                  cfg_select,
    input  logic [BANK_W-1:0]     cfg_bank,
    input  logic [INDEX_W-1:0]    cfg_index,
    input  logic [WIDTH-1:0]      cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BANK_W-1:0]     in_bank,
    input  logic [M*DATA_W-1:0]   in_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M*DATA_W-1:0]   out_flat,
    output logic                  err_bank
`ifdef FEC_CODEC_SEQ_DEBUG_EN
    ,
    output logic [M*WIDTH-1:0]    debug_decoded_flat
`endif
);

    localparam int RW = $clog2(M + 1);
    localparam logic [RW-1:0] R_LAST = RW'(M - 1);
    localparam logic [RW-1:0] R_DONE = RW'(M);

    typedef logic [WIDTH-1:0]   sym_t;
    typedef sym_t [M-1:0]       vec_t;
    typedef sym_t [M*M-1:0]     mat_t;
    typedef logic [DATA_W-1:0]  dsym_t;
    typedef dsym_t [M-1:0]      dvec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEC  = 2'd1,
        S_ENC  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Identity matrix: entries r*(M+1) are exactly the diagonal
    function automatic mat_t identity_mat();
        mat_t m;
        for (int i = 0; i < M * M; i++) begin
            m[i] = ((i % (M + 1)) == 0) ? sym_t'(1) : sym_t'(0);
        end
        return m;
    endfunction

    // Cyclic convolution over GF(2), indices wrap mod WIDTH
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (a[i] && b[j]) begin
                    p[(i + j) % WIDTH] = ~p[(i + j) % WIDTH];
                end
            end
        end
        return p;
    endfunction

    function automatic sym_t row_sum(input vec_t coef, input vec_t v);
        sym_t acc;
        acc = '0;
        for (int c = 0; c < M; c++) begin
            acc = acc ^ gf_mul(coef[c], v[c]);
        end
        return acc;
    endfunction

    // Fold the top bit back in: x^(WIDTH-1) equals the sum of all lower powers modulo the all-ones factor
    function automatic dsym_t project(input sym_t w);
        return w[DATA_W-1:0] ^ {DATA_W{w[WIDTH-1]}};
    endfunction

    state_t              state_q, state_d;
    logic [RW-1:0]       r_q, r_d;
    logic                accept;

    mat_t                dec_mem_q [NBANK];
    mat_t                enc_mem_q [NBANK];

    // Per-beat snapshot so a bank rewritten on the accept edge cannot disturb the beat
    mat_t                dec_w_q, enc_w_q;
    vec_t                lifted_q, decoded_q;
    dvec_t               result_q, out_flat_q;
    logic [BANK_W-1:0]   bank_q;
    logic                err_bank_q;

    vec_t                lifted;
    logic                bank_bad;
    logic [BANK_W-1:0]   bank_eff;
    mat_t                dec_sel, enc_sel;
    vec_t                row_coef;
    sym_t                row_val;

    assign bank_bad  = (32'(in_bank) >= 32'(NBANK));
    assign bank_eff  = bank_bad ? '0 : in_bank;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_flat  = out_flat_q;
    assign err_bank  = err_bank_q;
    assign cfg_ready = !((state_q != S_IDLE) && (cfg_bank == bank_q));

`ifdef FEC_CODEC_SEQ_DEBUG_EN
    assign debug_decoded_flat = decoded_q;
`endif

    // Lift each payload symbol by zero-extending to WIDTH bits
    always_comb begin
        lifted = '0;
        for (int k = 0; k < M; k++) begin
            lifted[k] = {1'b0, in_flat[k*DATA_W +: DATA_W]};
        end
    end

    // Pick the coefficient bank the incoming beat will snapshot
    always_comb begin
        dec_sel = dec_mem_q[0];
        enc_sel = enc_mem_q[0];
        for (int b = 1; b < NBANK; b++) begin
            if (bank_eff == BANK_W'(b)) begin
                dec_sel = dec_mem_q[b];
                enc_sel = enc_mem_q[b];
            end
        end
    end

    // One matrix row per cycle: coefficients of row r_q against the stage input vector
    always_comb begin
        row_coef = '0;
        for (int k = 0; k < M; k++) begin
            if (r_q == RW'(k)) begin
                row_coef = (state_q == S_ENC) ? enc_w_q[k*M +: M] : dec_w_q[k*M +: M];
            end
        end
        row_val = row_sum(row_coef, (state_q == S_ENC) ? decoded_q : lifted_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // Next state; ENC lingers one cycle at r == M so the output register loads a complete result
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_DEC;
                    r_d     = '0;
                end
            end
            S_DEC: begin
                if (r_q == R_LAST) begin
                    state_d = S_ENC;
                    r_d     = '0;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            S_ENC: begin
                if (r_q == R_DONE) begin
                    state_d = S_HOLD;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    r_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
    end

    // Datapath: capture, row-wise decode/encode, output register load on HOLD entry
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_w_q    <= '0;
            enc_w_q    <= '0;
            lifted_q   <= '0;
            decoded_q  <= '0;
            result_q   <= '0;
            out_flat_q <= '0;
            bank_q     <= '0;
            err_bank_q <= 1'b0;
        end else begin
            err_bank_q <= accept && bank_bad;
            if (accept) begin
                lifted_q <= lifted;
                dec_w_q  <= dec_sel;
                enc_w_q  <= enc_sel;
                bank_q   <= bank_eff;
            end
            for (int k = 0; k < M; k++) begin
                if (r_q == RW'(k)) begin
                    if (state_q == S_DEC) begin
                        decoded_q[k] <= row_val;
                    end
                    if (state_q == S_ENC) begin
                        result_q[k] <= project(row_val);
                    end
                end
            end
            if ((state_q == S_ENC) && (r_q == R_DONE)) begin
                out_flat_q <= result_q;
            end
        end
    end

    // Coefficient banks; out-of-range bank or index matches no entry and is silently dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                dec_mem_q[b] <= identity_mat();
                enc_mem_q[b] <= identity_mat();
            end
        end else if (cfg_we && cfg_ready) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < M * M; i++) begin
                    if ((cfg_bank == BANK_W'(b)) && (cfg_index == INDEX_W'(i))) begin
                        if (cfg_select) begin
                            enc_mem_q[b][i] <= cfg_data;
                        end else begin
                            dec_mem_q[b][i] <= cfg_data;
                        end
                    end
                end
            end
        end
    end

endmodule
